mm_exp_sched: RTL and testbench

MM_EXP_SCHED -- requirements
Module: mm_exp_sched

---
 rtl/mm_exp_sched_if.sv | 25 ++
 rtl/mm_exp_sched.sv | 76 +++++++
 tb/tb_mm_exp_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mm_exp_sched_if.sv
// mm_exp_sched_if: control, exponent-read and multiplier handshake bundle for mm_exp_sched
interface mm_exp_sched_if #(
  parameter int E_W  = 2048,
  parameter int EA_W = $clog2(E_W)
);
  logic            start;
  logic            abort;
  logic [EA_W:0]   exp_len;
  logic [EA_W-1:0] exp_rd_addr;
  logic            exp_rd_bit;
  logic            mm_req;
  logic [1:0]      mm_op_sel;
  logic            mm_done;
  logic            acc_init;
  logic            busy;
  logic            done;
  modport master (
    input  start, abort, exp_len, exp_rd_bit, mm_done,
    output exp_rd_addr, mm_req, mm_op_sel, acc_init, busy, done
  );
  modport slave (
    output start, abort, exp_len, exp_rd_bit, mm_done,
    input  exp_rd_addr, mm_req, mm_op_sel, acc_init, busy, done
  );
endinterface

// File: rtl/mm_exp_sched.sv
// mm_exp_sched: left-to-right square-and-multiply scheduler driving a Montgomery multiplier
module mm_exp_sched #(
  parameter int E_W  = 2048,
  parameter int EA_W = $clog2(E_W)
) (
  input logic            clk,
  input logic            rst_n,
  mm_exp_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, CONV_X, SQR, MUL, CONV_OUT, DONE} state_t;
  state_t          state, nxt;
  logic [EA_W-1:0] bit_idx, nxt_idx;
  logic            cur_bit, nxt_bit, len_zero, nxt_len0, req_q;
  logic            op, nxt_op, fire, second, bit_now;
  assign bus.exp_rd_addr = bit_idx;
  assign op      = state inside {CONV_X, SQR, MUL, CONV_OUT};
  assign nxt_op  = nxt inside {CONV_X, SQR, MUL, CONV_OUT};
  assign fire    = op && bus.mm_done && !bus.mm_req;
  assign second  = state == SQR && req_q;
  // a fast multiplier may finish on the capture cycle, so use the live bit then
  assign bit_now = second ? bus.exp_rd_bit : cur_bit;
  always_comb begin
    nxt      = state;
    nxt_idx  = bit_idx;
    nxt_bit  = second ? bus.exp_rd_bit : cur_bit;
    nxt_len0 = len_zero;
    case (state)
      IDLE: if (bus.start) begin
        nxt      = CONV_X;
        nxt_idx  = (bus.exp_len == '0) ? '0 : EA_W'(bus.exp_len - 1'b1);
        nxt_len0 = bus.exp_len == '0;
      end
      CONV_X: if (fire) nxt = len_zero ? CONV_OUT : SQR;
      SQR, MUL: if (fire) begin
        if (state == SQR && bit_now) nxt = MUL;
        else if (bit_idx == '0) nxt = CONV_OUT;
        else begin
          nxt     = SQR;
          nxt_idx = bit_idx - 1'b1;
        end
      end
      CONV_OUT: if (fire) nxt = DONE;
      default: nxt = IDLE;
    endcase
    if (bus.abort && state != IDLE) nxt = IDLE;
    if (nxt == IDLE) begin
      nxt_idx = '0;
      nxt_bit = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bit_idx       <= '0;
      cur_bit       <= 1'b0;
      len_zero      <= 1'b0;
      req_q         <= 1'b0;
      bus.mm_req    <= 1'b0;
      bus.mm_op_sel <= 2'd0;
      bus.acc_init  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= nxt;
      bit_idx       <= nxt_idx;
      cur_bit       <= nxt_bit;
      len_zero      <= nxt_len0;
      req_q         <= bus.mm_req;
      bus.mm_req    <= nxt_op && (fire || state == IDLE);
      bus.mm_op_sel <= nxt == SQR ? 2'd1 : nxt == MUL ? 2'd2 : nxt == CONV_OUT ? 2'd3 : 2'd0;
      bus.acc_init  <= state == IDLE && nxt == CONV_X;
      bus.busy      <= nxt_op;
      bus.done      <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_mm_exp_sched.sv
// tb_mm_exp_sched: directed checks of the exponentiation scheduler against a latency-modelled multiplier
module tb_mm_exp_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0, errors = 0;
  int          lat = 3, cnt = 0, done_cnt = 0, init_cnt = 0, n_ops = 0;
  logic        spur = 1'b0;
  int          ops[$], addrs[$], e_q[$];
  logic [63:0] expo = '0;
  logic [10:0] prev_addr = '0;

  mm_exp_sched_if bus ();
  mm_exp_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // multiplier + exponent memory model; acts 1 time unit after each rising edge
  initial begin
    bus.mm_done    = 1'b0;
    bus.exp_rd_bit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.mm_done    = 1'b0;
      bus.exp_rd_bit = expo[prev_addr[5:0]];
      prev_addr      = bus.exp_rd_addr;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.mm_done = 1'b1;
      end
      if (bus.mm_req) begin
        ops.push_back(int'(bus.mm_op_sel));
        if (bus.mm_op_sel == 2'd1) addrs.push_back(int'(bus.exp_rd_addr));
        cnt = lat;
        if (spur && bus.mm_op_sel == 2'd2) begin
          bus.mm_done = 1'b1;
          spur        = 1'b0;
        end
      end
      if (bus.done) done_cnt++;
      if (bus.acc_init) init_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input int len, input logic [63:0] e);
    ops.delete();
    addrs.delete();
    done_cnt     = 0;
    init_cnt     = 0;
    expo         = e;
    bus.exp_len  = 12'(len);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 500) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(bus.done), 1);
    chk({tag, "_busy_in_done"}, 64'(bus.busy), 0);
    tick();
    chk({tag, "_done_one_cycle"}, 64'(bus.done), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.exp_len = '0;
    #12;
    chk("rst_outs", {bus.mm_req, bus.acc_init, bus.busy, bus.done, bus.mm_op_sel, bus.exp_rd_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // exp_len = 0, started on the first edge after reset release
    start_op(0, 64'h0);
    chk("len0_first_busy", 64'(bus.busy), 1);
    chk("len0_first_req", 64'(bus.mm_req), 1);
    chk("len0_acc_init", 64'(bus.acc_init), 1);
    chk("len0_first_sel", 64'(bus.mm_op_sel), 0);
    wait_done("len0");
    e_q = '{0, 3};
    chk_seq("len0_ops", ops, e_q);
    chk("len0_init_cnt", 64'(init_cnt), 1);
    chk("len0_done_cnt", 64'(done_cnt), 1);

    // exponent 0b1011
    start_op(4, 64'hB);
    wait_done("b1011");
    e_q = '{0, 1, 2, 1, 1, 2, 1, 2, 3};
    chk_seq("b1011_ops", ops, e_q);
    e_q = '{3, 2, 1, 0};
    chk_seq("b1011_addr", addrs, e_q);
    chk("b1011_done_cnt", 64'(done_cnt), 1);
    chk("b1011_addr_idle", 64'(bus.exp_rd_addr), 0);

    // restart mid-SQR and spurious mm_done coincident with a MUL request
    spur = 1'b1;
    start_op(4, 64'hB);
    for (int n = 0; n < 100 && bus.mm_op_sel != 2'd1; n++) tick();
    chk("dist_in_sqr", 64'(bus.mm_op_sel), 1);
    bus.exp_len = 12'd1;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    wait_done("dist");
    e_q = '{0, 1, 2, 1, 1, 2, 1, 2, 3};
    chk_seq("dist_ops", ops, e_q);
    chk("dist_spur_fired", 64'(spur), 0);
    chk("dist_done_cnt", 64'(done_cnt), 1);

    // single-cycle multiplier: done lands on the bit-capture cycle, exponent 0b110
    lat = 1;
    start_op(3, 64'h6);
    wait_done("fast");
    e_q = '{0, 1, 2, 1, 2, 1, 3};
    chk_seq("fast_ops", ops, e_q);
    lat = 3;

    // abort during the second SQR, late mm_done follows
    start_op(4, 64'hB);
    for (int n = 0; n < 100 && addrs.size() < 2; n++) tick();
    chk("abort_second_sqr", 64'(addrs.size()), 2);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 0);
    chk("abort_req", 64'(bus.mm_req), 0);
    chk("abort_done", 64'(bus.done), 0);
    chk("abort_addr", 64'(bus.exp_rd_addr), 0);
    n_ops = ops.size();
    repeat (10) tick();
    chk("abort_no_req", 64'(ops.size()), 64'(n_ops));
    chk("abort_no_done", 64'(done_cnt), 0);
    start_op(4, 64'hB);
    wait_done("post_abort");
    e_q = '{0, 1, 2, 1, 1, 2, 1, 2, 3};
    chk_seq("post_abort_ops", ops, e_q);

    // asynchronous reset during MUL
    start_op(4, 64'hB);
    for (int n = 0; n < 100 && bus.mm_op_sel != 2'd2; n++) tick();
    chk("rst_in_mul", 64'(bus.mm_op_sel), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.mm_req, bus.acc_init, bus.busy, bus.done, bus.mm_op_sel, bus.exp_rd_addr}, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(1, 64'h1);
    chk("post_rst_busy", 64'(bus.busy), 1);
    wait_done("post_rst");
    e_q = '{0, 1, 2, 3};
    chk_seq("post_rst_ops", ops, e_q);
    chk("post_rst_done_cnt", 64'(done_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
